fetch_unit: RTL

Instruction fetch stage with a prefetch queue that sits directly upstream of the core datapath. It owns the fetch PC, issues word reads to instruction memory over a request/grant/response handshake with variable latency, and buffers returned instructions with their PCs. The datapath consumes them over a valid/ready interface. Taken branches, jumps and `jalr` targets arrive as a redirect, which flushes all in-flight and buffered work.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch queue and redirect flush
module fetch_unit #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             instr_valid,
    output logic [INS_W-1:0] instr,
    output logic [PC_W-1:0]  instr_pc,
    input  logic             instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  fpc;
    logic [CW-1:0]    occ, outst, discard, outst_nxt;
    logic [CW:0]      used;
    logic [AW-1:0]    qhead, qtail, phead, ptail;
    logic [INS_W-1:0] qins [DEPTH];
    logic [PC_W-1:0]  qpc  [DEPTH];
    logic [PC_W-1:0]  ppc  [DEPTH];
    logic             grant, drop, push, pop;
    logic             unused_rpc;

    assign unused_rpc = ^redirect_pc[1:0];

    // A queue slot is reserved at grant time, so occ+outst bounds both structures.
    always_comb begin
        used      = {1'b0, occ} + {1'b0, outst};
        imem_req  = !reset && (used < (CW+1)'(DEPTH));
        imem_addr = fpc;
        grant     = imem_req && imem_gnt;
        drop      = imem_rvalid && (discard != '0);
        push      = imem_rvalid && !drop && !redirect;
        pop       = instr_valid && instr_ready && !redirect;
        outst_nxt = outst + CW'(grant) - CW'(imem_rvalid);
    end

    assign instr_valid = (occ != '0);
    assign instr       = instr_valid ? qins[qhead] : '0;
    assign instr_pc    = instr_valid ? qpc[qhead]  : '0;

    always_ff @(posedge clk) begin
        if (grant) begin
            ppc[ptail] <= fpc;
        end
        if (push) begin
            qins[qtail] <= imem_rdata;
            qpc[qtail]  <= ppc[phead];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc     <= '0;
            occ     <= '0;
            outst   <= '0;
            discard <= '0;
            qhead   <= '0;
            qtail   <= '0;
            phead   <= '0;
            ptail   <= '0;
        end else begin
            if (grant) begin
                ptail <= ptail + AW'(1);
            end
            if (imem_rvalid) begin
                phead <= phead + AW'(1);
            end
            outst <= outst_nxt;
            // Everything still in flight after this cycle, including a same-cycle grant, is stale.
            if (redirect) begin
                fpc     <= {redirect_pc[PC_W-1:2], 2'b00};
                occ     <= '0;
                qhead   <= qtail;
                discard <= outst_nxt;
            end else begin
                if (grant) begin
                    fpc <= fpc + PC_W'(4);
                end
                if (push) begin
                    qtail <= qtail + AW'(1);
                end
                if (pop) begin
                    qhead <= qhead + AW'(1);
                end
                occ     <= occ + CW'(push) - CW'(pop);
                discard <= discard - CW'(drop);
            end
        end
    end

endmodule
